seg_display_mux: RTL and testbench

- Parametrised multiplexed seven-segment display driver for N hex digits on a common segment bus.
- Contains its own refresh prescaler, double-buffered display data, per-digit decimal point and blanking, optional leading-zero suppression, and PWM brightness control.
- Output polarity is configurable.
- Sits between system logic, which presents display values with a load strobe, and the board's segment and digit-select pins.

---
 rtl/seg_display_mux.sv | 197 +++++++++++++++++++
 tb/tb_seg_display_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: scans DIGITS hex digits over a shared
// segment bus with PWM brightness, double-buffered display data, per-digit
// decimal point / blanking and optional leading-zero suppression.
module seg_display_mux #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter int BRIGHT_W       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzb,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRE_W-1:0]    presc;
  logic [BRIGHT_W-1:0] sub;
  logic [IDX_W-1:0]    idx;

  logic [4*DIGITS-1:0] pend_val,   sh_val;
  logic [DIGITS-1:0]   pend_dp,    sh_dp;
  logic [DIGITS-1:0]   pend_blank, sh_blank;
  logic                pend_flag;

  logic tick, slot_tick, frame_tick;

  // Timing chain: prescaler tick -> sub-step wrap (slot) -> digit wrap (frame).
  assign tick       = en & (presc == PRE_MAX);
  assign slot_tick  = tick & (&sub);
  assign frame_tick = slot_tick & (idx == IDX_MAX);

  // Scan counters; all held at zero while disabled so re-enable starts at digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      sub   <= '0;
      idx   <= '0;
    end else if (!en) begin
      presc <= '0;
      sub   <= '0;
      idx   <= '0;
    end else begin
      if (tick) begin
        presc <= '0;
        sub   <= sub + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (slot_tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
    end
  end

  // Double buffer: loads land in pending; shadow only changes at a frame boundary,
  // or immediately while the scan is stopped since nothing is being displayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      pend_flag  <= 1'b0;
    end else if (!en) begin
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_blank <= blank;
        sh_val     <= value;
        sh_dp      <= dp_in;
        sh_blank   <= blank;
        pend_flag  <= 1'b0;
      end else if (pend_flag) begin
        sh_val     <= pend_val;
        sh_dp      <= pend_dp;
        sh_blank   <= pend_blank;
        pend_flag  <= 1'b0;
      end
    end else begin
      // Shadow takes the old pending contents even if a load arrives this cycle.
      if (frame_tick && pend_flag) begin
        sh_val   <= pend_val;
        sh_dp    <= pend_dp;
        sh_blank <= pend_blank;
      end
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_blank <= blank;
        pend_flag  <= 1'b1;
      end else if (frame_tick) begin
        pend_flag  <= 1'b0;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    // {g,f,e,d,c,b,a}, active high
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic [DIGITS-1:0] lz_mask;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_blank, cur_lz, lit;
  logic [DIGITS-1:0] dig_oh;

  // Leading-zero mask: a digit is suppressed when it and every digit above it is zero.
  always_comb begin
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (sh_val[i*4 +: 4] == 4'h0);
      lz_mask[i] = lzb & zero_above;
    end
  end

  // Select the shadow data for the digit currently being scanned.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = sh_val[i*4 +: 4];
        cur_dp    = sh_dp[i];
        cur_blank = sh_blank[i];
        cur_lz    = lz_mask[i];
      end
    end
  end

  // Last sub-step of each slot is always dark, which keeps adjacent digits from ghosting.
  assign lit    = en & (sub < brightness) & ~cur_blank & ~cur_lz;
  assign dig_oh = DIGITS'(1) << idx;

  // Registered pin drivers with polarity applied at the very end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      dig        <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      if (lit) begin
        seg <= hex7(cur_nib) ^ {7{SEG_ACTIVE_LOW}};
        dp  <= cur_dp ^ SEG_ACTIVE_LOW;
        dig <= dig_oh ^ {DIGITS{DIG_ACTIVE_LOW}};
      end else begin
        seg <= SEG_OFF;
        dp  <= DP_OFF;
        dig <= DIG_OFF;
      end
      frame_done <= frame_tick;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux with a 4-digit, short-timing configuration.
module tb_seg_display_mux;

  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 4;
  localparam int BRIGHT_W = 2;
  localparam int SUBN     = 1 << BRIGHT_W;
  localparam int SLOT     = CLK_DIV * SUBN;
  localparam int FRAME    = SLOT * DIGITS;

  // Glyphs {g,f,e,d,c,b,a}, lit = 1
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en = 1'b0;
  logic                 load = 1'b0;
  logic [4*DIGITS-1:0]  value = '0;
  logic [DIGITS-1:0]    dp_in = '0;
  logic [DIGITS-1:0]    blank = '0;
  logic                 lzb = 1'b0;
  logic [BRIGHT_W-1:0]  brightness = '0;
  logic [6:0]           seg;
  logic                 dp;
  logic [DIGITS-1:0]    dig;
  logic                 frame_done;

  int total = 0;
  int bad   = 0;

  seg_display_mux #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BRIGHT_W(BRIGHT_W),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .blank(blank), .lzb(lzb), .brightness(brightness),
    .seg(seg), .dp(dp), .dig(dig), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] dig;
    logic              fd;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: t counts enabled cycles since the scan (re)started.
  int                  m_t = 0;
  logic [4*DIGITS-1:0] m_sh_v = '0, m_pd_v = '0;
  logic [DIGITS-1:0]   m_sh_dp = '0, m_pd_dp = '0;
  logic [DIGITS-1:0]   m_sh_bl = '0, m_pd_bl = '0;
  bit                  m_flag = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t = 0;
      m_sh_v = '0; m_pd_v = '0; m_sh_dp = '0; m_pd_dp = '0;
      m_sh_bl = '0; m_pd_bl = '0; m_flag = 0;
      exp_q.delete();
    end else begin
      int idx, sub, nib, upper;
      bit lit, lz, boundary;
      logic [DIGITS-1:0] oh;
      exp_t e;
      idx   = (m_t / SLOT) % DIGITS;
      sub   = (m_t / CLK_DIV) % SUBN;
      upper = int'(m_sh_v) >> (4 * idx);
      nib   = upper & 15;
      lz    = lzb && (idx > 0) && (upper == 0);
      lit   = en && (sub < int'(brightness)) && !m_sh_bl[idx] && !lz;
      boundary = en && ((m_t % FRAME) == FRAME - 1);
      oh    = DIGITS'(1) << idx;
      e.seg = lit ? ~GLYPH[nib] : 7'h7F;
      e.dp  = lit ? ~m_sh_dp[idx] : 1'b1;
      e.dig = lit ? ~oh : {DIGITS{1'b1}};
      e.fd  = boundary;
      exp_q.push_back(e);
      if (en) begin
        if (boundary && m_flag) begin
          m_sh_v = m_pd_v; m_sh_dp = m_pd_dp; m_sh_bl = m_pd_bl;
        end
        if (load) begin
          m_pd_v = value; m_pd_dp = dp_in; m_pd_bl = blank; m_flag = 1;
        end else if (boundary) begin
          m_flag = 0;
        end
        m_t = m_t + 1;
      end else begin
        m_t = 0;
        if (load) begin
          m_pd_v = value; m_pd_dp = dp_in; m_pd_bl = blank;
          m_sh_v = value; m_sh_dp = dp_in; m_sh_bl = blank; m_flag = 0;
        end else if (m_flag) begin
          m_sh_v = m_pd_v; m_sh_dp = m_pd_dp; m_sh_bl = m_pd_bl; m_flag = 0;
        end
      end
    end
  end

  // Compare each registered output against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if ({seg, dp, dig, frame_done} !== {e.seg, e.dp, e.dig, e.fd}) begin
        bad++;
        $display("FAIL scan @%0t got seg=%h dp=%b dig=%b fd=%b want seg=%h dp=%b dig=%b fd=%b",
                 $time, seg, dp, dig, frame_done, e.seg, e.dp, e.dig, e.fd);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] d,
                         input logic [DIGITS-1:0] b);
    value = v; dp_in = d; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance to the negedge just before a frame-boundary edge.
  task automatic to_boundary();
    int n;
    n = 0;
    while (!(en && (m_t % FRAME) == FRAME - 1) && n < FRAME + 2) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= FRAME + 2) begin
      bad++;
      $display("FAIL boundary_wait got %0d cycles want < %0d", n, FRAME + 2);
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if ({seg, dp, dig, frame_done} !== {7'h7F, 1'b1, {DIGITS{1'b1}}, 1'b0}) begin
      bad++;
      $display("FAIL %s got seg=%h dp=%b dig=%b fd=%b want seg=7f dp=1 dig=1111 fd=0",
               name, seg, dp, dig, frame_done);
    end
  endtask

  initial begin
    cycles(3);
    #1 check_idle("reset_state");
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    brightness = 2'd3;
    do_load(16'h135F, 4'b0000, 4'b0000);
    cycles(3 * FRAME);

    do_load(16'h0042, 4'b0000, 4'b0000);
    cycles(2 * FRAME);
    lzb = 1'b1;
    cycles(FRAME);
    do_load(16'h0000, 4'b0000, 4'b0000);
    cycles(2 * FRAME);
    lzb = 1'b0;

    brightness = 2'd0;
    cycles(FRAME);
    brightness = 2'd1;
    cycles(FRAME);
    brightness = 2'd3;

    cycles(7);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    to_boundary();
    do_load(16'h5555, 4'b0000, 4'b0000);
    cycles(3 * FRAME);

    do_load(16'h8888, 4'b0100, 4'b0001);
    cycles(2 * FRAME);

    cycles(21);
    en = 1'b0;
    cycles(5);
    do_load(16'h7777, 4'b0000, 4'b0000);
    cycles(4);
    en = 1'b1;
    cycles(FRAME + 3);

    for (int k = 0; k < 40; k++) begin
      en         = ($urandom_range(0, 7) != 0);
      brightness = BRIGHT_W'($urandom_range(0, SUBN - 1));
      lzb        = $urandom_range(0, 1) != 0;
      value      = 16'($urandom) >> (4 * $urandom_range(0, 3));
      dp_in      = DIGITS'($urandom);
      blank      = ($urandom_range(0, 3) == 0) ? DIGITS'($urandom) : '0;
      case ($urandom_range(0, 3))
        0: do_load(value, dp_in, blank);
        1: begin
          if (en) begin
            to_boundary();
            do_load(value, dp_in, blank);
          end
        end
        default: ;
      endcase
      value = 16'($urandom);
      cycles($urandom_range(1, 120));
    end

    en = 1'b1;
    brightness = 2'd3;
    do_load(16'h9C0D, 4'b1010, 4'b0000);
    cycles(FRAME + 10);
    #3 rst = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    rst = 1'b1;
    cycles(FRAME);

    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
